// File: rtl/barramento_coerencia.sv
// barramento_coerencia: snooping-bus arbiter for the MSI coherence system.
// It picks one requesting emitter per transaction (round-robin), performs the
// optional write-back of the dirty block to memory, broadcasts the message on
// the snoop bus and returns a one-cycle completion pulse to the winner.
//
// Ports:
//   clock, reset          rising-edge clock, asynchronous active-low reset
//   req[N_PROC]           per-processor request, held until its done pulse
//   msg[2*N_PROC]         2-bit message per processor (11 = semMensagem)
//   endereco              block address per processor, packed by index
//   wb[N_PROC]            write-back request per processor
//   dado_wb               write-back data per processor, packed by index
//   mem_pronto            memory accepted the write (used in WRITEBACK only)
//   mem_we/mem_end/mem_dado          memory write port
//   bus_valido/bus_msg/bus_end/bus_origem  snoop bus broadcast
//   done[N_PROC]          one-hot completion pulse to the winner
module barramento_coerencia #(
    parameter int unsigned N_PROC = 3,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [N_PROC-1:0]          req,
    input  logic [2*N_PROC-1:0]        msg,
    input  logic [ADDR_W*N_PROC-1:0]   endereco,
    input  logic [N_PROC-1:0]          wb,
    input  logic [DATA_W*N_PROC-1:0]   dado_wb,
    input  logic                       mem_pronto,
    output logic                       mem_we,
    output logic [ADDR_W-1:0]          mem_end,
    output logic [DATA_W-1:0]          mem_dado,
    output logic                       bus_valido,
    output logic [1:0]                 bus_msg,
    output logic [ADDR_W-1:0]          bus_end,
    output logic [1:0]                 bus_origem,
    output logic [N_PROC-1:0]          done
);

    localparam int unsigned MSG_W   = 2;
    localparam int unsigned IDX_W   = 2;
    localparam logic [MSG_W-1:0] SEM_MSG = 2'b11;

    typedef enum logic [1:0] {
        OCIOSO    = 2'd0,
        WRITEBACK = 2'd1,
        DIFUSAO   = 2'd2,
        CONCLUI   = 2'd3
    } estado_t;

    estado_t             estado, estado_n;
    logic [IDX_W-1:0]    ultimo, ultimo_n;
    logic [IDX_W-1:0]    venc_q, venc_n;
    logic [MSG_W-1:0]    msg_q, msg_n;
    logic [ADDR_W-1:0]   end_q, end_n;
    logic [DATA_W-1:0]   dado_q, dado_n;

    logic                achou;
    logic [IDX_W-1:0]    grant;
    int                  cand;
    logic [MSG_W-1:0]    msg_sel;
    logic                wb_sel;

    // Round-robin search: first requester at or after ultimo+1, wrapping upward.
    always_comb begin
        achou = 1'b0;
        grant = '0;
        cand  = 0;
        for (int i = 1; i <= int'(N_PROC); i++) begin
            cand = int'(ultimo) + i;
            if (cand >= int'(N_PROC)) begin
                cand = cand - int'(N_PROC);
            end
            if (!achou && (|(req & (N_PROC'(1) << cand)))) begin
                achou = 1'b1;
                grant = IDX_W'(cand);
            end
        end
    end

    // Winner's message and write-back flag, extracted from the packed inputs.
    assign msg_sel = MSG_W'(msg >> (MSG_W * 32'(grant)));
    assign wb_sel  = |(wb & (N_PROC'(1) << grant));

    // Next state and next latch contents.
    always_comb begin
        estado_n = estado;
        ultimo_n = ultimo;
        venc_n   = venc_q;
        msg_n    = msg_q;
        end_n    = end_q;
        dado_n   = dado_q;
        unique case (estado)
            OCIOSO: begin
                if (achou) begin
                    venc_n = grant;
                    msg_n  = msg_sel;
                    end_n  = ADDR_W'(endereco >> (ADDR_W * 32'(grant)));
                    dado_n = DATA_W'(dado_wb >> (DATA_W * 32'(grant)));
                    if (wb_sel) begin
                        estado_n = WRITEBACK;
                    end else if (msg_sel == SEM_MSG) begin
                        estado_n = CONCLUI;
                    end else begin
                        estado_n = DIFUSAO;
                    end
                end
            end
            WRITEBACK: begin
                if (mem_pronto) begin
                    estado_n = (msg_q == SEM_MSG) ? CONCLUI : DIFUSAO;
                end
            end
            DIFUSAO: begin
                estado_n = CONCLUI;
            end
            CONCLUI: begin
                ultimo_n = venc_q;
                estado_n = OCIOSO;
            end
            default: begin
                estado_n = OCIOSO;
            end
        endcase
    end

    // State, latches and strobes; strobes are registered from the next state
    // so they line up with the state they belong to.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado     <= OCIOSO;
            ultimo     <= IDX_W'(N_PROC - 1);
            venc_q     <= '0;
            msg_q      <= SEM_MSG;
            end_q      <= '0;
            dado_q     <= '0;
            mem_we     <= 1'b0;
            bus_valido <= 1'b0;
            bus_msg    <= SEM_MSG;
            done       <= '0;
        end else begin
            estado     <= estado_n;
            ultimo     <= ultimo_n;
            venc_q     <= venc_n;
            msg_q      <= msg_n;
            end_q      <= end_n;
            dado_q     <= dado_n;
            mem_we     <= (estado_n == WRITEBACK);
            bus_valido <= (estado_n == DIFUSAO);
            bus_msg    <= (estado_n == DIFUSAO) ? msg_n : SEM_MSG;
            done       <= (estado_n == CONCLUI) ? (N_PROC'(1) << venc_n) : '0;
        end
    end

    // Address/data/origin simply expose the latched transaction.
    assign mem_end    = end_q;
    assign mem_dado   = dado_q;
    assign bus_end    = end_q;
    assign bus_origem = venc_q;

endmodule

// File: tb/tb_barramento_coerencia.sv
// Scoreboard bench for barramento_coerencia: stimulus pushes expected bus,
// memory and completion events (with their cycle stamps) into a queue; a
// monitor on the falling edge pops and compares every event the DUT shows.
module tb_barramento_coerencia;

    localparam int N  = 3;
    localparam int AW = 4;
    localparam int DW = 8;

    localparam int K_MEM  = 0;
    localparam int K_BUS  = 1;
    localparam int K_DONE = 2;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [N-1:0]      req;
    logic [2*N-1:0]    msg;
    logic [AW*N-1:0]   endereco;
    logic [N-1:0]      wb;
    logic [DW*N-1:0]   dado_wb;
    logic              mem_pronto;
    logic              mem_we;
    logic [AW-1:0]     mem_end;
    logic [DW-1:0]     mem_dado;
    logic              bus_valido;
    logic [1:0]        bus_msg;
    logic [AW-1:0]     bus_end;
    logic [1:0]        bus_origem;
    logic [N-1:0]      done;

    barramento_coerencia #(.N_PROC(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clock      (clock),
        .reset      (reset),
        .req        (req),
        .msg        (msg),
        .endereco   (endereco),
        .wb         (wb),
        .dado_wb    (dado_wb),
        .mem_pronto (mem_pronto),
        .mem_we     (mem_we),
        .mem_end    (mem_end),
        .mem_dado   (mem_dado),
        .bus_valido (bus_valido),
        .bus_msg    (bus_msg),
        .bus_end    (bus_end),
        .bus_origem (bus_origem),
        .done       (done)
    );

    always #5 clock = ~clock;

    typedef struct {
        int         kind;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] c;
        int         cyc;
    } evt_t;

    evt_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   t;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic push(input int kind, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] c, input int at);
        evt_t e;
        e.kind = kind; e.a = a; e.b = b; e.c = c; e.cyc = at;
        q.push_back(e);
    endtask

    task automatic observe(input int kind, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] c);
        evt_t e;
        checks++;
        if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event kind=%0d a=%h b=%h c=%h cyc=%0d, none required",
                     kind, a, b, c, cyc);
        end else begin
            e = q.pop_front();
            if (e.kind != kind || e.a != a || e.b != b || e.c != c || e.cyc != cyc) begin
                errors++;
                $display("FAIL event got kind=%0d a=%h b=%h c=%h cyc=%0d, required kind=%0d a=%h b=%h c=%h cyc=%0d",
                         kind, a, b, c, cyc, e.kind, e.a, e.b, e.c, e.cyc);
            end
        end
    endtask

    // Monitor: every strobe the DUT raises must match the head of the queue.
    always @(negedge clock) begin
        if (reset) begin
            if (mem_we) observe(K_MEM, 8'(mem_end), mem_dado, 8'h00);
            if (bus_valido) begin
                observe(K_BUS, 8'(bus_msg), 8'(bus_end), 8'(bus_origem));
            end else begin
                checks++;
                if (bus_msg != 2'b11) begin
                    errors++;
                    $display("FAIL idle_bus_msg got=%b required=11 cyc=%0d", bus_msg, cyc);
                end
            end
            if (done != '0) observe(K_DONE, 8'(done), 8'h00, 8'h00);
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h required=%h", name, got, exp);
        end
    endtask

    task automatic check_rst(input string n);
        chk({n, "_mem_we"},     32'(mem_we),     32'h0);
        chk({n, "_bus_valido"}, 32'(bus_valido), 32'h0);
        chk({n, "_bus_msg"},    32'(bus_msg),    32'h3);
        chk({n, "_bus_end"},    32'(bus_end),    32'h0);
        chk({n, "_bus_origem"}, 32'(bus_origem), 32'h0);
        chk({n, "_mem_end"},    32'(mem_end),    32'h0);
        chk({n, "_mem_dado"},   32'(mem_dado),   32'h0);
        chk({n, "_done"},       32'(done),       32'h0);
    endtask

    task automatic drained(input string n);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL %s_missing_events got=%0d pending required=0", n, q.size());
        end
        q.delete();
    endtask

    // One clock; requesters drop their bit once they see their done pulse.
    task automatic tick();
        @(posedge clock);
        #1;
        req = req & ~done;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic setp(input int i, input logic [1:0] m, input logic [3:0] a,
                        input logic w, input logic [7:0] d);
        msg[2*i +: 2]       = m;
        endereco[AW*i +: AW] = a;
        wb[i]               = w;
        dado_wb[DW*i +: DW] = d;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog_timeout got=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        req = '0; msg = '1; endereco = '0; wb = '0; dado_wb = '0; mem_pronto = 1'b0;
        #1 reset = 1'b0;
        #2 check_rst("reset");
        run(2);
        reset = 1'b1;
        tick();

        // Single readMiss from proc 0; later address change must be ignored.
        t = cyc;
        setp(0, 2'b01, 4'd5, 1'b0, 8'h00);
        req = 3'b001;
        push(K_BUS, 8'h01, 8'h05, 8'h00, t + 1);
        push(K_DONE, 8'h01, 8'h00, 8'h00, t + 2);
        tick();
        endereco[3:0] = 4'hF;
        run(3);
        drained("readmiss");

        // Write-back from proc 1 with mem_pronto low for two sampled cycles.
        t = cyc;
        setp(1, 2'b10, 4'd3, 1'b1, 8'hA5);
        req = 3'b010;
        push(K_MEM, 8'h03, 8'hA5, 8'h00, t + 1);
        push(K_MEM, 8'h03, 8'hA5, 8'h00, t + 2);
        push(K_MEM, 8'h03, 8'hA5, 8'h00, t + 3);
        push(K_BUS, 8'h02, 8'h03, 8'h01, t + 4);
        push(K_DONE, 8'h02, 8'h00, 8'h00, t + 5);
        tick();
        dado_wb[15:8] = 8'hFF;
        run(2);
        mem_pronto = 1'b1;
        tick();
        mem_pronto = 1'b0;
        run(3);
        drained("writeback");

        // Round-robin after reset: order 0, 1, 2.
        reset = 1'b0;
        tick();
        reset = 1'b1;
        t = cyc;
        setp(0, 2'b01, 4'd1, 1'b0, 8'h00);
        setp(1, 2'b10, 4'd2, 1'b0, 8'h00);
        setp(2, 2'b00, 4'd3, 1'b0, 8'h00);
        req = 3'b111;
        push(K_BUS, 8'h01, 8'h01, 8'h00, t + 1);
        push(K_DONE, 8'h01, 8'h00, 8'h00, t + 2);
        push(K_BUS, 8'h02, 8'h02, 8'h01, t + 4);
        push(K_DONE, 8'h02, 8'h00, 8'h00, t + 5);
        push(K_BUS, 8'h00, 8'h03, 8'h02, t + 7);
        push(K_DONE, 8'h04, 8'h00, 8'h00, t + 8);
        run(10);
        drained("rr_first");
        chk("rr_first_req_cleared", 32'(req), 32'h0);

        // Proc 0 alone, leaving ultimo=0.
        t = cyc;
        setp(0, 2'b01, 4'd7, 1'b0, 8'h00);
        req = 3'b001;
        push(K_BUS, 8'h01, 8'h07, 8'h00, t + 1);
        push(K_DONE, 8'h01, 8'h00, 8'h00, t + 2);
        run(4);
        drained("rr_prime");

        // Second burst with ultimo=0: order 1, 2, 0.
        t = cyc;
        req = 3'b111;
        push(K_BUS, 8'h02, 8'h02, 8'h01, t + 1);
        push(K_DONE, 8'h02, 8'h00, 8'h00, t + 2);
        push(K_BUS, 8'h00, 8'h03, 8'h02, t + 4);
        push(K_DONE, 8'h04, 8'h00, 8'h00, t + 5);
        push(K_BUS, 8'h01, 8'h07, 8'h00, t + 7);
        push(K_DONE, 8'h01, 8'h00, 8'h00, t + 8);
        run(10);
        drained("rr_second");

        // semMensagem without write-back: done one cycle after latch, no bus.
        t = cyc;
        setp(2, 2'b11, 4'd8, 1'b0, 8'h00);
        req = 3'b100;
        push(K_DONE, 8'h04, 8'h00, 8'h00, t + 1);
        run(3);
        drained("semmsg");

        // semMensagem with write-back; mem_pronto high in OCIOSO is ignored.
        t = cyc;
        setp(2, 2'b11, 4'd9, 1'b1, 8'h3C);
        req = 3'b100;
        mem_pronto = 1'b1;
        push(K_MEM, 8'h09, 8'h3C, 8'h00, t + 1);
        push(K_DONE, 8'h04, 8'h00, 8'h00, t + 2);
        run(2);
        mem_pronto = 1'b0;
        run(2);
        drained("semmsg_wb");

        // Leave ultimo=0 so proc 1 would normally win next.
        t = cyc;
        setp(0, 2'b01, 4'd4, 1'b0, 8'h00);
        req = 3'b001;
        push(K_BUS, 8'h01, 8'h04, 8'h00, t + 1);
        push(K_DONE, 8'h01, 8'h00, 8'h00, t + 2);
        run(4);
        drained("pre_rst");

        // Reset during WRITEBACK drops the transaction; proc 0 regains priority.
        t = cyc;
        setp(1, 2'b10, 4'd6, 1'b1, 8'h66);
        req = 3'b011;
        push(K_MEM, 8'h06, 8'h66, 8'h00, t + 1);
        run(2);
        chk("wb_before_rst_mem_we", 32'(mem_we), 32'h1);
        #2 reset = 1'b0;
        #1 check_rst("rst_in_wb");
        drained("rst_in_wb");
        tick();
        reset = 1'b1;
        mem_pronto = 1'b1;
        t = cyc;
        push(K_BUS, 8'h01, 8'h04, 8'h00, t + 1);
        push(K_DONE, 8'h01, 8'h00, 8'h00, t + 2);
        push(K_MEM, 8'h06, 8'h66, 8'h00, t + 4);
        push(K_BUS, 8'h02, 8'h06, 8'h01, t + 5);
        push(K_DONE, 8'h02, 8'h00, 8'h00, t + 6);
        run(8);
        mem_pronto = 1'b0;
        drained("after_rst");
        chk("final_req_cleared", 32'(req), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
